// File: rtl/bk_multiword_add_seq.sv
// bk_multiword_add_seq: multi-word adder sequencer around a single W-bit adder.
// It adds the operands one W-bit chunk per cycle, least-significant chunk first.
// The carry between chunks is kept in a register.
module bk_multiword_add_seq #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] sum,
    output logic               cout,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_cin,
    input  logic [W-1:0]       add_s,
    input  logic               add_cout
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [W*WORDS-1:0]   r_a;
    logic [W*WORDS-1:0]   r_b;
    logic                 r_carry;
    logic [W*WORDS-1:0]   r_sum;
    logic                 r_cout;
    logic                 w_accept;
    logic                 w_last;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_idx == LAST_IDX);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    // State register; an asynchronous reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, step through the chunks, hold the result until it is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Drive the adder from the current chunk only while running; otherwise drive all zeros.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == RUN) begin
            add_a   = r_a[int'(r_idx)*W +: W];
            add_b   = r_b[int'(r_idx)*W +: W];
            add_cin = r_carry;
        end
    end

    // Operand latch, chunk index, inter-chunk carry and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_sum[int'(r_idx)*W +: W] <= add_s;
                r_carry                   <= add_cout;
                if (w_last) begin
                    r_cout <= add_cout;
                    r_idx  <= '0;
                end else begin
                    r_idx  <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Testbench for bk_multiword_add_seq.
// A behavioural W-bit adder is attached to the add_* ports.
module tb_bk_multiword_add_seq;

    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int FW    = W * WORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] sum;
    logic          cout;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_s;
    logic          add_cout;
    logic [W:0]    w_add;

    int n_checks = 0;
    int n_pass   = 0;
    logic obs_cin  [WORDS];
    logic obs_cout [WORDS];

    always #5 clk = ~clk;

    // Behavioural stand-in for the attached W-bit adder.
    assign w_add    = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_s    = w_add[W-1:0];
    assign add_cout = w_add[W];

    bk_multiword_add_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // One complete transaction with its latency, result and handshake checks.
    task automatic run_op(input logic [FW-1:0] ta, input logic [FW-1:0] tb_v, input logic tcin,
                          input logic [FW-1:0] es, input logic ec, input string nm);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_v; cin = tcin; out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s.idle_ready: got %b want 1", nm, in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0; a = '1; b = '1; cin = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            obs_cin[k]  = add_cin;
            obs_cout[k] = add_cout;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL %s.run%0d: out_valid=%b in_ready=%b want 0/0", nm, k, out_valid, in_ready);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL %s.out_valid: got %b want 1", nm, out_valid);
        else n_pass++;
        n_checks++;
        if (sum !== es) $display("FAIL %s.sum: got %h want %h", nm, sum, es);
        else n_pass++;
        n_checks++;
        if (cout !== ec) $display("FAIL %s.cout: got %b want %b", nm, cout, ec);
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s.release: out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 64'h5; b = 64'h6; cin = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset.hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
        n_checks++;
        if (sum !== '0 || cout !== 1'b0) $display("FAIL reset.result: sum=%h cout=%b want 0/0", sum, cout);
        else n_pass++;
        n_checks++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0)
            $display("FAIL reset.adder: a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
        else n_pass++;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset.idle_after: in_ready=%b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_chunk_carry();
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, "chunk_carry");
        n_checks++;
        if (obs_cin[0] !== 1'b0 || obs_cin[1] !== 1'b1)
            $display("FAIL chunk_carry.add_cin: run0=%b run1=%b want 0/1", obs_cin[0], obs_cin[1]);
        else n_pass++;
    endtask

    task automatic test_all_ones();
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, "all_ones");
        for (int k = 0; k < WORDS; k++) begin
            n_checks++;
            if (obs_cout[k] !== 1'b1) $display("FAIL all_ones.add_cout%0d: got %b want 1", k, obs_cout[k]);
            else n_pass++;
        end
    endtask

    task automatic test_patterns();
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, "msb_overflow");
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, "mixed");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; a = 64'h0; b = 64'h1; cin = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        a = 64'h2; b = 64'h3;
        repeat (WORDS) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 64'h1 || cout !== 1'b0)
                $display("FAIL bp.hold%0d: ov=%b ir=%b sum=%h cout=%b want 1/0/1/0",
                         k, out_valid, in_ready, sum, cout);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp.idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp.accept: in_ready=%b want 0", in_ready);
        else n_pass++;
        repeat (WORDS) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 64'h5 || cout !== 1'b0)
            $display("FAIL bp.second: ov=%b sum=%h cout=%b want 1/5/0", out_valid, sum, cout);
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit seen_valid;
        @(negedge clk);
        in_valid = 1'b1; a = 64'h1111_1111_1111_1111; b = 64'h1; cin = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (add_a !== 16'h1111) $display("FAIL midrst.chunk2: add_a=%h want 1111", add_a);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0)
            $display("FAIL midrst.state: ov=%b ir=%b sum=%h want 0/1/0", out_valid, in_ready, sum);
        else n_pass++;
        n_checks++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0)
            $display("FAIL midrst.adder: a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) $display("FAIL midrst.no_pulse: out_valid seen=%b want 0", seen_valid);
        else n_pass++;
        run_op(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] ra [16];
        logic [FW-1:0] rb [16];
        logic          rc [16];
        logic [FW:0]   ref_v;
        int  n_acc, n_res, last_acc;
        bit  load_next;
        for (int i = 0; i < 16; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
            rc[i] = 1'($urandom_range(0, 1));
        end
        ra[0] = '1; rb[0] = '1; rc[0] = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        a = ra[0]; b = rb[0]; cin = rc[0];
        n_acc = 0; n_res = 0; last_acc = 0; load_next = 1'b0;
        for (int cyc = 0; cyc < 200 && n_res < 16; cyc++) begin
            if (load_next) begin
                load_next = 1'b0;
                if (n_acc < 16) begin
                    a = ra[n_acc]; b = rb[n_acc]; cin = rc[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                ref_v = {1'b0, ra[n_res]} + {1'b0, rb[n_res]} + {{FW{1'b0}}, rc[n_res]};
                n_checks++;
                if ({cout, sum} !== ref_v)
                    $display("FAIL b2b.result%0d: got %b_%h want %b_%h", n_res, cout, sum, ref_v[FW], ref_v[FW-1:0]);
                else n_pass++;
                n_res++;
            end
            if (in_ready === 1'b1 && in_valid === 1'b1) begin
                if (n_acc > 0) begin
                    n_checks++;
                    if (cyc - last_acc != WORDS + 2)
                        $display("FAIL b2b.interval%0d: got %0d want %0d", n_acc, cyc - last_acc, WORDS + 2);
                    else n_pass++;
                end
                last_acc  = cyc;
                n_acc++;
                load_next = 1'b1;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n_res != 16) $display("FAIL b2b.timeout: results=%0d want 16", n_res);
        else n_pass++;
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_chunk_carry();
        test_all_ones();
        test_patterns();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
